// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci pair serializer.
//   fib_pair_t : one (num, num2) pair as produced by the double-rate generator
//   FIB_W      : default number width
//   CNT_W      : width of the accepted-beat counter
//   sat_inc    : saturating increment for CNT_W counters
package fib_pkg;
  localparam int FIB_W = 16;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [FIB_W-1:0] num;   // older element, emitted first
    logic [FIB_W-1:0] num2;  // newer element, emitted second
  } fib_pair_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous FIFO of fib_pair_t entries with registered full/empty.
// Ports:
//   clk, rst (async active-low), clr (sync flush)
//   push/wdata : write a pair (ignored when full)
//   pop        : drop the head pair (ignored when empty)
//   rdata      : current head pair (valid when !empty)
//   full/empty : occupancy flags derived from the stored count
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  fib_pair_t wdata,
  output fib_pair_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fib_pair_t      mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    cnt;
  logic           do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/fib_pair_serializer.sv
// Accepts (num, num2) pairs from a double-rate Fibonacci generator, buffers
// them in a small FIFO and emits one value per handshake (num, then num2).
// An inline checker watches the emitted stream for recurrence breaks and
// modular wrap-around.
// Ports:
//   clk, rst (async active-low), clr (sync clear of everything)
//   in_valid/in_ready/in_num/in_num2 : pair input handshake
//   out_valid/out_ready/out_data     : serialized value output handshake
//   seq_err   : sticky, emitted value != sum of the previous two
//   wrap_seen : sticky, emitted value smaller than the previous one
//   out_count : accepted output beats, saturating
// The pair type is built on FIB_W; WIDTH is expected to equal FIB_W.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             seq_err,
  output logic             wrap_seen,
  output logic [CNT_W-1:0] out_count
);
  fib_pair_t        wr_pair, head;
  logic             full, empty;
  logic             push, pop, beat;
  logic             alive;      // low only while in reset; gates in_ready
  logic             phase;      // 0: emit head.num, 1: emit head.num2
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] hold;       // last presented value, shown when empty
  logic [WIDTH-1:0] p1, p2;     // newest and previous accepted values
  logic [1:0]       hist_cnt;   // accepted history depth, saturates at 2
  logic [WIDTH-1:0] sum;

  assign wr_pair.num  = in_num;
  assign wr_pair.num2 = in_num2;

  // in_ready depends only on registered state, so a pop in the same cycle
  // cannot open space for a push into a full FIFO.
  assign in_ready  = alive & ~full;
  assign out_valid = ~empty;
  assign sel       = phase ? head.num2 : head.num;
  assign out_data  = empty ? hold : sel;
  assign beat      = out_valid & out_ready;

  // clr wins over both handshakes.
  assign push = in_valid & in_ready & ~clr;
  assign pop  = beat & phase & ~clr;
  assign sum  = p1 + p2;

  fib_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pair),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive     <= 1'b0;
      phase     <= 1'b0;
      hold      <= '0;
      p1        <= '0;
      p2        <= '0;
      hist_cnt  <= '0;
      seq_err   <= 1'b0;
      wrap_seen <= 1'b0;
      out_count <= '0;
    end else if (clr) begin
      alive     <= 1'b1;
      phase     <= 1'b0;
      hold      <= '0;
      p1        <= '0;
      p2        <= '0;
      hist_cnt  <= '0;
      seq_err   <= 1'b0;
      wrap_seen <= 1'b0;
      out_count <= '0;
    end else begin
      alive <= 1'b1;
      hold  <= out_data;
      if (beat) begin
        phase <= ~phase;
        if (hist_cnt == 2'd2 && out_data != sum) seq_err   <= 1'b1;
        if (hist_cnt != 2'd0 && out_data < p1)   wrap_seen <= 1'b1;
        p2        <= p1;
        p1        <= out_data;
        if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
        out_count <= sat_inc(out_count);
      end
    end
  end
endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer: streaming, backpressure, checker
// flags, async reset mid-stream and clear-with-push.
module tb_fib_pair_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_num = '0, in_num2 = '0;
  logic        in_ready, out_valid, seq_err, wrap_seen;
  logic [15:0] out_data;
  logic [31:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] got_q[$];

  always #5 clk = ~clk;

  fib_pair_serializer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_num2(in_num2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .seq_err(seq_err), .wrap_seen(wrap_seen), .out_count(out_count)
  );

  // Record every beat the sink accepts at the following posedge.
  always @(negedge clk)
    if (rst && !clr && out_valid && out_ready) got_q.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    in_valid = 1'b1; in_num = a; in_num2 = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic wait_val(input logic [15:0] v, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_data == v) begin ok = 1; break; end
    end
  endtask

  task automatic check_q(input string tag, input logic [15:0] e[$]);
    chk({tag, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < got_q.size()) chk(tag, {16'd0, got_q[i]}, {16'd0, e[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_q[$];
    bit ok;

    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_wrap", wrap_seen, 0);
    @(negedge clk) rst = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Stream and sequence check
    out_ready = 1'b1; got_q.delete();
    push(16'd1, 16'd1);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_data", out_data, 1);
    push(16'd2, 16'd3);
    push(16'd5, 16'd8);
    repeat (8) step();
    exp_q = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    check_q("stream", exp_q);
    chk("stream_count", out_count, 6);
    chk("stream_seq_err", seq_err, 0);
    chk("stream_wrap", wrap_seen, 0);
    chk("empty_valid", out_valid, 0);
    chk("empty_hold", out_data, 8);

    // Backpressure and full
    do_clr();
    out_ready = 1'b0; got_q.delete();
    push(16'd20, 16'd21);
    push(16'd22, 16'd23);
    push(16'd24, 16'd25);
    push(16'd26, 16'd27);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_num = 16'd28; in_num2 = 16'd29;
    repeat (3) step();
    chk("held_in_ready", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 20);
    out_ready = 1'b1;
    push(16'd28, 16'd29);
    repeat (12) step();
    exp_q = '{16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27, 16'd28, 16'd29};
    check_q("drain", exp_q);
    chk("drain_count", out_count, 10);

    // Recurrence violation
    do_clr();
    push(16'd1, 16'd1);
    push(16'd2, 16'd4);
    wait_val(16'd4, ok);
    chk("see_4", ok, 1);
    chk("seq_before_4", seq_err, 0);
    @(negedge clk);
    chk("seq_after_4", seq_err, 1);
    push(16'd6, 16'd10);
    repeat (4) step();
    chk("seq_sticky", seq_err, 1);
    do_clr();
    chk("seq_clr", seq_err, 0);

    // Wrap-around: 75025 and 121393 mod 65536
    push(16'd28657, 16'd46368);
    push(16'd9489, 16'd55857);
    wait_val(16'd9489, ok);
    chk("see_9489", ok, 1);
    chk("wrap_before", wrap_seen, 0);
    @(negedge clk);
    chk("wrap_after", wrap_seen, 1);
    repeat (4) step();
    chk("wrap_seq_err", seq_err, 0);
    chk("wrap_count", out_count, 4);

    // Async reset mid-stream, 3 pairs queued, phase=1
    out_ready = 1'b0; got_q.delete();
    push(16'd7, 16'd8);
    push(16'd9, 16'd10);
    push(16'd11, 16'd12);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pre_rst_count", out_count, 5);
    chk("pre_rst_phase1", out_data, 8);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", out_count, 0);
    chk("arst_wrap", wrap_seen, 0);
    chk("arst_seq", seq_err, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_data", out_data, 0);
    @(negedge clk) rst = 1'b1;
    step();
    got_q.delete();
    out_ready = 1'b1;
    push(16'd1, 16'd1);
    repeat (3) step();
    exp_q = '{16'd1, 16'd1};
    check_q("post_arst", exp_q);
    chk("post_arst_count", out_count, 2);

    // Clear with simultaneous push (and an offered beat)
    out_ready = 1'b0;
    push(16'd3, 16'd4);
    chk("pre_clr_valid", out_valid, 1);
    clr = 1'b1; in_valid = 1'b1; in_num = 16'd5; in_num2 = 16'd6; out_ready = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_count", out_count, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_data", out_data, 0);
    step();
    chk("clr_push_dropped", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
